// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer: reads a frame buffer in raster order and streams the
// pixels over a valid/ready interface with start-of-frame, end-of-line and
// end-of-frame markers. Read data is parked in a 2-entry output FIFO so that
// back-pressure never loses a returning pixel.
// Optional feature macro: FRAME_PIXEL_STREAMER_TEST_PATTERN_EN adds a
// pattern_en input that swaps the frame buffer for a vertical zebra pattern.
module frame_pixel_streamer #(
  parameter int IMG_WIDTH   = 320,
  parameter int IMG_HEIGHT  = 240,
  parameter int W           = 8,
  parameter int STRIPE_LOG2 = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
`ifdef FRAME_PIXEL_STREAMER_TEST_PATTERN_EN
  input  logic                                   pattern_en,
`endif
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   rd_en,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] rd_addr,
  input  logic [W-1:0]                           rd_data,
  output logic                                   y_valid,
  input  logic                                   y_ready,
  output logic [W-1:0]                           y_data,
  output logic                                   y_sof,
  output logic                                   y_eol,
  output logic                                   y_eof
);

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam int XW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} streamState_t;

  streamState_t r_state;
  streamState_t w_nextState;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [AW-1:0] r_addr;

  logic          r_infValid;
  logic [2:0]    r_infMarks;

  logic [W-1:0]  r_fifoData  [2];
  logic [2:0]    r_fifoMarks [2];
  logic          r_rdPtr;
  logic          r_wrPtr;
  logic [1:0]    r_count;
  logic          r_done;

  logic          w_issue;
  logic          w_accept;
  logic          w_pop;
  logic          w_lastPix;
  logic          w_room;
  logic [2:0]    w_level;
  logic          w_issueSof;
  logic          w_issueEol;
  logic          w_issueEof;
  logic [W-1:0]  w_pushData;

  assign y_valid    = (r_count != 2'd0);
  assign w_pop      = y_valid && y_ready;
  assign w_lastPix  = w_pop && r_fifoMarks[r_rdPtr][0];
  assign w_level    = {1'b0, r_count} + {2'b0, r_infValid};
  // The slot freed by this cycle's pop counts as room, so a steady stream
  // keeps one read per cycle without ever overrunning the two entries.
  assign w_room     = (w_level < (3'd2 + {2'b0, w_pop}));
  assign w_issueSof = (r_x == '0) && (r_y == '0);
  assign w_issueEol = (r_x == XW'(IMG_WIDTH - 1));
  assign w_issueEof = w_issueEol && (r_y == YW'(IMG_HEIGHT - 1));

  assign busy       = (r_state != IDLE);
  assign frame_done = r_done;
  assign rd_addr    = r_addr;
  assign y_data     = r_fifoData[r_rdPtr];
  assign y_sof      = y_valid && r_fifoMarks[r_rdPtr][2];
  assign y_eol      = y_valid && r_fifoMarks[r_rdPtr][1];
  assign y_eof      = y_valid && r_fifoMarks[r_rdPtr][0];

`ifdef FRAME_PIXEL_STREAMER_TEST_PATTERN_EN
  logic          r_pattern;
  logic          r_infStripe;
  logic          w_stripe;
  logic [XW-1:0] w_xShift;

  assign w_xShift   = r_x >> STRIPE_LOG2;
  assign w_stripe   = ~|(w_xShift & XW'(1));
  assign rd_en      = w_issue && !r_pattern;
  assign w_pushData = r_pattern ? {W{r_infStripe}} : rd_data;

  // Latch the pixel source with the accepted start and track the stripe of the in-flight pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern   <= 1'b0;
      r_infStripe <= 1'b0;
    end else begin
      if (w_accept) r_pattern <= pattern_en;
      r_infStripe <= w_stripe;
    end
  end
`else
  assign rd_en      = w_issue;
  assign w_pushData = rd_data;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state decode plus read-issue and start-accept strobes
  always_comb begin
    w_nextState = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = STREAM;
          w_accept    = 1'b1;
        end
      end
      STREAM: begin
        w_issue = w_room;
        if (w_room && w_issueEof) w_nextState = DRAIN;
      end
      DRAIN: begin
        if (w_lastPix) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Raster counters and the one-deep record of the read currently in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_addr     <= '0;
      r_infValid <= 1'b0;
      r_infMarks <= '0;
    end else begin
      if (w_accept) begin
        r_x    <= '0;
        r_y    <= '0;
        r_addr <= '0;
      end else if (w_issue) begin
        if (w_issueEol) begin
          r_x <= '0;
          r_y <= w_issueEof ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
        r_addr <= w_issueEof ? '0 : r_addr + 1'b1;
      end
      r_infValid <= w_issue;
      r_infMarks <= {w_issueSof, w_issueEol, w_issueEof};
    end
  end

  // Two-entry output FIFO: returning pixel pushed, head popped on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifoData[0]  <= '0;
      r_fifoData[1]  <= '0;
      r_fifoMarks[0] <= '0;
      r_fifoMarks[1] <= '0;
      r_rdPtr        <= 1'b0;
      r_wrPtr        <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      if (r_infValid) begin
        r_fifoData[r_wrPtr]  <= w_pushData;
        r_fifoMarks[r_wrPtr] <= r_infMarks;
        r_wrPtr              <= ~r_wrPtr;
      end
      if (w_pop) r_rdPtr <= ~r_rdPtr;
      r_count <= r_count + {1'b0, r_infValid} - {1'b0, w_pop};
    end
  end

  // Completion pulse in the cycle after the last pixel leaves
  always_ff @(posedge clk) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= w_lastPix;
  end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// tb_frame_pixel_streamer: directed scenarios with randomized data and
// back-pressure, checked against a pixel-index reference model.
module tb_frame_pixel_streamer;

  localparam int WID  = 4;
  localparam int HGT  = 2;
  localparam int NPIX = WID * HGT;
  localparam int DW   = 8;
  localparam int AW   = $clog2(NPIX);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          yReady;
  logic          busy;
  logic          frameDone;
  logic          rdEn;
  logic          yValid;
  logic          ySof;
  logic          yEol;
  logic          yEof;
  logic [AW-1:0] rdAddr;
  logic [DW-1:0] rdData;
  logic [DW-1:0] yData;
  logic [DW-1:0] mem [NPIX];

  int errors = 0;
  int checks = 0;
  int cycleNo = 0;
  int gotIdx = 0;
  int doneCount = 0;
  int lastHsCycle = -10;
  int firstValidCycle = -1;
  int rdEnCount = 0;
  int startCycle = 0;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData = '0;
  logic [2:0]    prevMarks = '0;

  // Free-running clock
  always #5 clk = ~clk;

  // Frame-buffer model: one-cycle read latency, garbage when not read
  always @(posedge clk) rdData <= rdEn ? mem[rdAddr] : DW'($urandom);

`ifdef FRAME_PIXEL_STREAMER_TEST_PATTERN_EN
  logic patternEn = 1'b0;
`endif

  frame_pixel_streamer #(
    .IMG_WIDTH(WID), .IMG_HEIGHT(HGT), .W(DW), .STRIPE_LOG2(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef FRAME_PIXEL_STREAMER_TEST_PATTERN_EN
    .pattern_en(patternEn),
`endif
    .busy(busy), .frame_done(frameDone), .rd_en(rdEn), .rd_addr(rdAddr),
    .rd_data(rdData), .y_valid(yValid), .y_ready(yReady), .y_data(yData),
    .y_sof(ySof), .y_eol(yEol), .y_eof(yEof)
  );

`ifdef FRAME_PIXEL_STREAMER_TEST_PATTERN_EN
  localparam int PWID = 64;
  localparam int PNPIX = PWID * 2;
  logic                      pStart;
  logic                      pReady;
  logic                      pBusy, pDone, pRdEn, pValid, pSof, pEol, pEof;
  logic [$clog2(PNPIX)-1:0]  pRdAddr;
  logic [DW-1:0]             pData;
  logic [DW-1:0]             pRdData = 8'h5A;

  frame_pixel_streamer #(
    .IMG_WIDTH(PWID), .IMG_HEIGHT(2), .W(DW), .STRIPE_LOG2(4)
  ) pdut (
    .clk(clk), .rst(rst), .start(pStart), .pattern_en(1'b1),
    .busy(pBusy), .frame_done(pDone), .rd_en(pRdEn), .rd_addr(pRdAddr),
    .rd_data(pRdData), .y_valid(pValid), .y_ready(pReady), .y_data(pData),
    .y_sof(pSof), .y_eol(pEol), .y_eof(pEof)
  );
`endif

  // One comparison: counted, and reported on mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle monitor: stall stability, pixel order/markers, done timing
  task automatic observeCycle();
    cycleNo++;
    if (prevStall) begin
      checkOutput("stallValid", 32'(yValid), 32'(1));
      checkOutput("stallData", 32'(yData), 32'(prevData));
      checkOutput("stallMarks", 32'({ySof, yEol, yEof}), 32'(prevMarks));
    end
    if (yValid && firstValidCycle < 0) firstValidCycle = cycleNo;
    if (yValid && yReady) begin
      if (gotIdx < NPIX) begin
        checkOutput("pixelData", 32'(yData), 32'(mem[gotIdx]));
        checkOutput("pixelMarks", 32'({ySof, yEol, yEof}),
                    32'({gotIdx == 0, (gotIdx % WID) == WID - 1, gotIdx == NPIX - 1}));
      end else begin
        checkOutput("extraPixel", 32'(gotIdx), 32'(NPIX - 1));
      end
      gotIdx++;
      lastHsCycle = cycleNo;
    end
    if (frameDone) begin
      doneCount++;
      checkOutput("doneTiming", 32'(cycleNo), 32'(lastHsCycle + 1));
      checkOutput("doneAllPixels", 32'(gotIdx), 32'(NPIX));
      checkOutput("doneBusyLow", 32'(busy), 32'(0));
    end
    if (rdEn) rdEnCount++;
    prevStall = yValid && !yReady;
    prevData  = yData;
    prevMarks = {ySof, yEol, yEof};
  endtask

  // Drive inputs just after the falling edge, then sample settled outputs
  task automatic applyStimulus(input logic s, input logic r);
    @(negedge clk);
    start  = s;
    yReady = r;
    #1;
    observeCycle();
  endtask

  task automatic beginFrame();
    gotIdx = 0;
    doneCount = 0;
    firstValidCycle = -1;
    rdEnCount = 0;
  endtask

  // Run until frame_done or the cycle budget runs out
  task automatic runFrame(input logic holdStart, input logic randomReady, input int budget);
    int n = 0;
    while (doneCount == 0 && n < budget) begin
      applyStimulus(holdStart, randomReady ? ($urandom_range(0, 9) < 3) : 1'b1);
      n++;
    end
    checkOutput("frameCompleted", 32'(doneCount), 32'(1));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    yReady = 1'b0;
`ifdef FRAME_PIXEL_STREAMER_TEST_PATTERN_EN
    pStart = 1'b0;
    pReady = 1'b1;
`endif
    for (int i = 0; i < NPIX; i++) mem[i] = DW'(i);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstBusy", 32'(busy), 32'(0));
    checkOutput("rstDone", 32'(frameDone), 32'(0));
    checkOutput("rstRdEn", 32'(rdEn), 32'(0));
    checkOutput("rstValid", 32'(yValid), 32'(0));
    checkOutput("rstMarks", 32'({ySof, yEol, yEof}), 32'(0));
    checkOutput("rstAddr", 32'(rdAddr), 32'(0));
    checkOutput("rstData", 32'(yData), 32'(0));
    rst = 1'b0;

    // Scenario 1: address-valued memory, always ready
    $display("[TB] scenario 1: basic frame");
    beginFrame();
    applyStimulus(1'b1, 1'b1);
    startCycle = cycleNo;
    runFrame(1'b0, 1'b0, 40);
    checkOutput("firstValidLatency", 32'(firstValidCycle - startCycle), 32'(3));
    checkOutput("noBubbles", 32'(lastHsCycle - firstValidCycle), 32'(NPIX - 1));
    checkOutput("readsPerFrame", 32'(rdEnCount), 32'(NPIX));

    // Scenario 2: random data, sparse ready
    $display("[TB] scenario 2: random back-pressure");
    for (int i = 0; i < NPIX; i++) mem[i] = DW'($urandom);
    beginFrame();
    applyStimulus(1'b1, $urandom_range(0, 9) < 3);
    runFrame(1'b0, 1'b1, 400);
    checkOutput("readsPerFrameStalled", 32'(rdEnCount), 32'(NPIX));

    // Scenario 3: start held high through a frame
    $display("[TB] scenario 3: start held");
    beginFrame();
    applyStimulus(1'b1, 1'b1);
    runFrame(1'b1, 1'b0, 40);
    beginFrame();
    applyStimulus(1'b0, 1'b1);
    checkOutput("restartBusy", 32'(busy), 32'(1));
    runFrame(1'b0, 1'b0, 40);
    repeat (4) applyStimulus(1'b0, 1'b1);
    checkOutput("noQueuedFrame", 32'(busy), 32'(0));

    // Scenario 4: reset while pixel 3 is on the bus
    $display("[TB] scenario 4: mid-frame reset");
    beginFrame();
    applyStimulus(1'b1, 1'b1);
    for (int n = 0; n < 20 && gotIdx < 3; n++) applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("preResetPixel3", 32'(yData), 32'(mem[3]));
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("postResetValid", 32'(yValid), 32'(0));
    checkOutput("postResetBusy", 32'(busy), 32'(0));
    prevStall = 1'b0;
    doneCount = 0;
    repeat (5) applyStimulus(1'b0, 1'b1);
    checkOutput("noDoneAfterReset", 32'(doneCount), 32'(0));
    for (int i = 0; i < NPIX; i++) mem[i] = DW'($urandom);
    beginFrame();
    applyStimulus(1'b1, 1'b1);
    runFrame(1'b0, 1'b0, 40);

`ifdef FRAME_PIXEL_STREAMER_TEST_PATTERN_EN
    // Scenario 5: zebra pattern source on a 64-wide frame
    $display("[TB] scenario 5: test pattern");
    begin : patternScenario
      int pIdx;
      int pRdCount;
      int pDoneSeen;
      pIdx = 0;
      pRdCount = 0;
      pDoneSeen = 0;
      for (int n = 0; n < 400 && pDoneSeen == 0; n++) begin
        @(negedge clk);
        pStart = (n == 0);
        #1;
        if (pRdEn) pRdCount++;
        if (pDone) pDoneSeen = 1;
        if (pValid && pReady && pIdx < PNPIX) begin
          checkOutput("patternData", 32'(pData),
                      32'((((pIdx % PWID) / 16) % 2 == 0) ? 8'hFF : 8'h00));
          checkOutput("patternMarks", 32'({pSof, pEol, pEof}),
                      32'({pIdx == 0, (pIdx % PWID) == PWID - 1, pIdx == PNPIX - 1}));
          pIdx++;
        end
      end
      checkOutput("patternCount", 32'(pIdx), 32'(PNPIX));
      checkOutput("patternDone", 32'(pDoneSeen), 32'(1));
      checkOutput("patternNoRead", 32'(pRdCount), 32'(0));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
